// File: rtl/siso_shift_seq_ctrl_if.sv
// Parallel handshake plus serial register link for siso_shift_seq_ctrl.
// slave  : the sequencer side (accepts words, drives the register chain).
// master : the environment side (producer/consumer and the register model).
interface siso_shift_seq_ctrl_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic             ready;
   logic [WIDTH-1:0] tx_data;
   logic             dir;
   logic             mod;
   logic             shift_en;
   logic             ser_out;
   logic             ser_in;
   logic [WIDTH-1:0] rx_data;
   logic             rx_valid;
   logic             busy;

   modport slave (
      input  start, tx_data, dir, ser_in,
      output ready, mod, shift_en, ser_out, rx_data, rx_valid, busy
   );

   modport master (
      output start, tx_data, dir, ser_in,
      input  ready, mod, shift_en, ser_out, rx_data, rx_valid, busy
   );
endinterface

// File: rtl/siso_shift_seq_ctrl.sv
// Sequencer for a bidirectional serial-in/serial-out shift register.
// Takes a parallel word over start/ready, streams it into the register one
// bit per clock, captures the bits coming back LAT edges later and
// reassembles the word, presenting it with a one-cycle rx_valid pulse.
// Optional build macro SISO_LOOPCHK_EN adds an err output that flags a
// mismatch between the sent word and the word received back.
module siso_shift_seq_ctrl #(
   parameter int WIDTH = 4,
   parameter int LAT   = WIDTH + 1,
   parameter int CNT_W = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   siso_shift_seq_ctrl_if.slave     bus
`ifdef SISO_LOOPCHK_EN
   ,
   output logic                     err
`endif
);

   // Last SHIFT cycle index and first capture cycle index.
   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(LAT + WIDTH - 1);
   localparam logic [CNT_W-1:0] LAT_C  = CNT_W'(LAT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             ready_q;
   logic             mod_q;
   logic             shift_en_q;
   logic             ser_out_q;
   logic             rx_valid_q;
   logic [WIDTH-1:0] rx_data_q;

   // tx_sh holds the remaining bits in transmit order, current bit at [0].
   logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
   // rx_sh assembles the returning bits directly into word order.
   logic [WIDTH-1:0] rx_sh_q, rx_sh_d;

   logic accept;
   logic capture;

   function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] w);
      logic [WIDTH-1:0] r;
      for (int i = 0; i < WIDTH; i++) begin
         r[i] = w[WIDTH-1-i];
      end
      return r;
   endfunction

   assign accept  = ready_q && bus.start;
   assign capture = (state_q == SHIFT) && (cnt_q >= LAT_C);

   // Next values of the transmit and receive shadow registers.
   always_comb begin
      tx_sh_d = tx_sh_q;
      rx_sh_d = rx_sh_q;
      if (accept) begin
         // MSB-first runs are stored reversed so both directions shift right.
         tx_sh_d = bus.dir ? bit_rev(bus.tx_data) : bus.tx_data;
      end else if (state_q == SHIFT) begin
         tx_sh_d = tx_sh_q >> 1;
      end
      if (capture) begin
         // LSB-first fills from the top down, MSB-first from the bottom up,
         // so bit j lands at j or WIDTH-1-j after WIDTH captures.
         if (mod_q) begin
            rx_sh_d = {rx_sh_q[WIDTH-2:0], bus.ser_in};
         end else begin
            rx_sh_d = {bus.ser_in, rx_sh_q[WIDTH-1:1]};
         end
      end
   end

   // Datapath shadows; contents are meaningless outside a run, so no reset.
   always_ff @(posedge clk) begin
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
   end

   // Control FSM with registered outputs; reset aborts any run in progress.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         ready_q    <= 1'b1;
         mod_q      <= 1'b0;
         shift_en_q <= 1'b0;
         ser_out_q  <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_data_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               rx_valid_q <= 1'b0;
               if (accept) begin
                  state_q    <= SHIFT;
                  ready_q    <= 1'b0;
                  mod_q      <= bus.dir;
                  shift_en_q <= 1'b1;
                  ser_out_q  <= tx_sh_d[0];
                  cnt_q      <= '0;
               end
            end
            SHIFT: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == LAST_C) begin
                  state_q    <= DONE;
                  shift_en_q <= 1'b0;
                  ser_out_q  <= 1'b0;
                  rx_valid_q <= 1'b1;
                  rx_data_q  <= rx_sh_d;
               end else begin
                  // Zeros shift in behind the word, giving ser_out=0 once drained.
                  ser_out_q <= tx_sh_d[0];
               end
            end
            DONE: begin
               state_q    <= IDLE;
               rx_valid_q <= 1'b0;
               ready_q    <= 1'b1;
            end
            default: begin
               state_q    <= IDLE;
               ready_q    <= 1'b1;
               shift_en_q <= 1'b0;
               ser_out_q  <= 1'b0;
               rx_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ready    = ready_q;
   assign bus.busy     = ~ready_q;
   assign bus.mod      = mod_q;
   assign bus.shift_en = shift_en_q;
   assign bus.ser_out  = ser_out_q;
   assign bus.rx_data  = rx_data_q;
   assign bus.rx_valid = rx_valid_q;

`ifdef SISO_LOOPCHK_EN
   logic [WIDTH-1:0] tx_word_q;
   logic             err_q;

   // Untouched copy of the accepted word for the loopback compare.
   always_ff @(posedge clk) begin
      if (accept) begin
         tx_word_q <= bus.tx_data;
      end
   end

   // Loopback error flag, refreshed once per run while in DONE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else if (state_q == DONE) begin
         err_q <= (rx_data_q != tx_word_q);
      end
   end

   assign err = err_q;
`endif

endmodule

// File: tb/tb_siso_shift_seq_ctrl.sv
// Bench for siso_shift_seq_ctrl: a 5-deep delay line stands in for the
// 4-stage register with registered output; words are streamed through it
// and the returned word, serial stream and handshake timing are checked.
module tb_siso_shift_seq_ctrl;

   localparam int W = 4;

   logic clk = 1'b0;
   logic rst;
   logic stuck = 1'b0;
   logic [4:0] dl = '0;

   int total  = 0;
   int passed = 0;

   siso_shift_seq_ctrl_if #(.WIDTH(W)) bus ();

`ifdef SISO_LOOPCHK_EN
   logic err;
   siso_shift_seq_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus), .err(err));
`else
   siso_shift_seq_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

   always #5 clk = ~clk;

   // Register model: every bit pushed in reappears on ser_in 5 shifts later.
   always @(posedge clk) begin
      if (bus.shift_en) dl <= {dl[3:0], bus.ser_out};
   end
   assign bus.ser_in = stuck ? 1'b0 : dl[4];

   typedef struct packed {
      logic [3:0] tx;
      logic       dir;
      logic [3:0] ser;   // ser[k] = expected ser_out in cycle k
      logic [3:0] rx;
   } vec_t;

   vec_t tbl [5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
   endtask

   function automatic logic [3:0] ser_order(input logic [3:0] tx, input logic d);
      logic [3:0] s;
      for (int k = 0; k < 4; k++) s[k] = d ? tx[3-k] : tx[k];
      return s;
   endfunction

   task automatic accept(input logic [3:0] tx, input logic d);
      int n = 0;
      while (!bus.ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n == 50) chk("accept_ready", 32'(bus.ready), 1);
      bus.start   = 1'b1;
      bus.tx_data = tx;
      bus.dir     = d;
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   // Called just after the acceptance edge; returns at negedge of cycle 10.
   task automatic watch_run(input logic [3:0] tx, input logic d, input logic [3:0] ser,
                            input logic [3:0] rx, input logic noise);
      for (int k = 0; k <= 10; k++) begin
         @(negedge clk);
         if (k < 9) begin
            chk($sformatf("shift_en k%0d", k), 32'(bus.shift_en), 1);
            chk($sformatf("ready k%0d", k), 32'(bus.ready), 0);
            chk($sformatf("busy k%0d", k), 32'(bus.busy), 1);
            chk($sformatf("rx_valid k%0d", k), 32'(bus.rx_valid), 0);
            chk($sformatf("mod k%0d", k), 32'(bus.mod), 32'(d));
            chk($sformatf("ser_out k%0d", k), 32'(bus.ser_out), (k < 4) ? 32'(ser[k]) : 0);
            if (noise) begin
               bus.start   = 1'($urandom);
               bus.tx_data = 4'($urandom);
               bus.dir     = 1'($urandom);
            end
         end else if (k == 9) begin
            if (noise) bus.start = 1'b0;
            chk("rx_valid k9", 32'(bus.rx_valid), 1);
            chk("rx_data k9", 32'(bus.rx_data), 32'(rx));
            chk("shift_en k9", 32'(bus.shift_en), 0);
            chk("ser_out k9", 32'(bus.ser_out), 0);
            chk("ready k9", 32'(bus.ready), 0);
         end else begin
            chk("ready k10", 32'(bus.ready), 1);
            chk("busy k10", 32'(bus.busy), 0);
            chk("rx_valid k10", 32'(bus.rx_valid), 0);
            chk("rx_data held k10", 32'(bus.rx_data), 32'(rx));
         end
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " ready"}, 32'(bus.ready), 1);
      chk({tag, " busy"}, 32'(bus.busy), 0);
      chk({tag, " mod"}, 32'(bus.mod), 0);
      chk({tag, " shift_en"}, 32'(bus.shift_en), 0);
      chk({tag, " ser_out"}, 32'(bus.ser_out), 0);
      chk({tag, " rx_valid"}, 32'(bus.rx_valid), 0);
      chk({tag, " rx_data"}, 32'(bus.rx_data), 0);
`ifdef SISO_LOOPCHK_EN
      chk({tag, " err"}, 32'(err), 0);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] tx;
      logic       d;

      tbl[0] = '{tx: 4'b1011, dir: 1'b0, ser: 4'b1011, rx: 4'b1011};
      tbl[1] = '{tx: 4'b1011, dir: 1'b1, ser: 4'b1101, rx: 4'b1011};
      tbl[2] = '{tx: 4'b0110, dir: 1'b1, ser: 4'b0110, rx: 4'b0110};
      tbl[3] = '{tx: 4'b1000, dir: 1'b0, ser: 4'b1000, rx: 4'b1000};
      tbl[4] = '{tx: 4'b0001, dir: 1'b1, ser: 4'b1000, rx: 4'b0001};

      rst         = 1'b0;
      bus.start   = 1'b0;
      bus.tx_data = '0;
      bus.dir     = 1'b0;

      // Reset state, during and after reset with start held low.
      @(negedge clk);
      chk_reset_vals("in_reset");
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk_reset_vals("idle");

      // Table-driven runs.
      for (int i = 0; i < 5; i++) begin
         accept(tbl[i].tx, tbl[i].dir);
         watch_run(tbl[i].tx, tbl[i].dir, tbl[i].ser, tbl[i].rx, 1'b0);
      end

      // start held through a run: second word taken only once ready returns.
      @(negedge clk);
      bus.start = 1'b1; bus.tx_data = 4'b0110; bus.dir = 1'b0;
      @(posedge clk);
      #1 bus.tx_data = 4'b1111;
      watch_run(4'b0110, 1'b0, 4'b0110, 4'b0110, 1'b0);
      @(posedge clk);
      #1 bus.start = 1'b0;
      watch_run(4'b1111, 1'b0, 4'b1111, 4'b1111, 1'b0);

      // Reset mid-run at k=5 aborts without rx_valid.
      accept(4'b1100, 1'b1);
      for (int k = 0; k <= 5; k++) @(negedge clk);
      rst = 1'b0;
      #1 chk_reset_vals("abort");
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk($sformatf("no rx_valid after abort %0d", k), 32'(bus.rx_valid), 0);
      end
      accept(4'b1001, 1'b0);
      watch_run(4'b1001, 1'b0, 4'b1001, 4'b1001, 1'b0);

      // Random words, directions, gaps and ignored requests while busy.
      for (int i = 0; i < 24; i++) begin
         tx = 4'($urandom);
         d  = 1'($urandom);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         accept(tx, d);
         watch_run(tx, d, ser_order(tx, d), tx, 1'b1);
      end

`ifdef SISO_LOOPCHK_EN
      // Broken loop returns zeros and raises err; a clean run clears it.
      stuck = 1'b1;
      accept(4'b0101, 1'b0);
      watch_run(4'b0101, 1'b0, 4'b0101, 4'b0000, 1'b0);
      chk("err stuck", 32'(err), 1);
      stuck = 1'b0;
      accept(4'b0101, 1'b0);
      watch_run(4'b0101, 1'b0, 4'b0101, 4'b0101, 1'b0);
      chk("err clean", 32'(err), 0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
